// File: rtl/daq_adc_reader.sv
// Reads one frame of ADC channel words over a parallel cs_n/rd_n bus after each conversion and
// queues them in a first-word-fall-through FIFO. Optional macro ADC_CHAN_TAG_EN adds channel tags.
module daq_adc_reader #(
  parameter int unsigned NUM_CHANNELS   = 8,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned RD_LOW_CYCLES  = 3,
  parameter int unsigned RD_HIGH_CYCLES = 2,
  parameter int unsigned FIFO_DEPTH     = 32,
  parameter int unsigned BUSY_TIMEOUT   = 4000
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  en_i,
  input  logic                  busy_i,
  input  logic [DATA_WIDTH-1:0] adc_db_i,
  output logic                  adc_cs_n_o,
  output logic                  adc_rd_n_o,
  output logic [DATA_WIDTH-1:0] sample_o,
  output logic [2:0]            chan_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  frame_done_o,
  output logic                  overflow_o,
  output logic                  timeout_o
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned TW   = $clog2(BUSY_TIMEOUT + 1);
  localparam int unsigned CMAX = (RD_LOW_CYCLES > RD_HIGH_CYCLES) ? RD_LOW_CYCLES : RD_HIGH_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {StIdle, StConv, StRdLow, StRdHigh, StDone} state_e;

  // Busy synchroniser and registered edge detectors
  logic busy_meta_q, busy_meta_d;
  logic busy_s_q, busy_s_d;
  logic busy_d1_q, busy_d1_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [CW-1:0]   cyc_q, cyc_d;
  logic [2:0]      ch_q, ch_d;
  logic            ovf_q, ovf_d;
  logic            to_q, to_d;

  logic [PW:0]     wptr_q, wptr_d;
  logic [PW:0]     rptr_q, rptr_d;
  logic [PW:0]     count;
  logic [PW:0]     free;
  logic            push;
  logic            pop;
  logic            ovf_set;
  logic            to_set;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

  always_comb begin
    busy_meta_d = busy_i;
    busy_s_d    = busy_meta_q;
    busy_d1_d   = busy_s_q;
    rise_d      = busy_s_q & ~busy_d1_q;
    fall_d      = ~busy_s_q & busy_d1_q;
  end

  always_comb begin
    count   = wptr_q - rptr_q;
    free    = (PW + 1)'(FIFO_DEPTH) - count;
    valid_o = (wptr_q != rptr_q);
    pop     = valid_o & ready_i;
  end

  // Control FSM; strobes are decoded from state, plus cs_n on the CONV exit cycle
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    cyc_d        = cyc_q;
    ch_d         = ch_q;
    push         = 1'b0;
    ovf_set      = 1'b0;
    to_set       = 1'b0;
    adc_cs_n_o   = 1'b1;
    adc_rd_n_o   = 1'b1;
    frame_done_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise_q && en_i) begin
          state_d = StConv;
          timer_d = '0;
        end
      end
      StConv: begin
        timer_d = timer_q + 1'b1;
        if (fall_q) begin
          if (free >= (PW + 1)'(NUM_CHANNELS)) begin
            state_d    = StRdLow;
            ch_d       = '0;
            cyc_d      = '0;
            adc_cs_n_o = 1'b0;
          end else begin
            state_d = StIdle;
            ovf_set = 1'b1;
          end
        end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
          state_d = StIdle;
          to_set  = 1'b1;
        end
      end
      StRdLow: begin
        adc_cs_n_o = 1'b0;
        adc_rd_n_o = 1'b0;
        if (cyc_q == CW'(RD_LOW_CYCLES - 1)) begin
          push    = 1'b1;
          cyc_d   = '0;
          state_d = StRdHigh;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StRdHigh: begin
        adc_cs_n_o = 1'b0;
        if (cyc_q == CW'(RD_HIGH_CYCLES - 1)) begin
          cyc_d = '0;
          if (ch_q == 3'(NUM_CHANNELS - 1)) begin
            state_d = StDone;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = StRdLow;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      StDone: begin
        frame_done_o = 1'b1;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ovf_d  = ovf_q | ovf_set;
    to_d   = to_q | to_set;
    wptr_d = wptr_q + {{PW{1'b0}}, push};
    rptr_d = rptr_q + {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      busy_meta_q <= 1'b0;
      busy_s_q    <= 1'b0;
      busy_d1_q   <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      state_q     <= StIdle;
      timer_q     <= '0;
      cyc_q       <= '0;
      ch_q        <= '0;
      ovf_q       <= 1'b0;
      to_q        <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      busy_meta_q <= busy_meta_d;
      busy_s_q    <= busy_s_d;
      busy_d1_q   <= busy_d1_d;
      rise_q      <= rise_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      timer_q     <= timer_d;
      cyc_q       <= cyc_d;
      ch_q        <= ch_d;
      ovf_q       <= ovf_d;
      to_q        <= to_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      mem_q[wptr_q[PW-1:0]] <= adc_db_i;
    end
  end

  assign sample_o   = valid_o ? mem_q[rptr_q[PW-1:0]] : '0;
  assign overflow_o = ovf_q;
  assign timeout_o  = to_q;

`ifdef ADC_CHAN_TAG_EN
  logic [2:0] tag_mem_q [FIFO_DEPTH];

  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      tag_mem_q[wptr_q[PW-1:0]] <= ch_q;
    end
  end

  assign chan_o = valid_o ? tag_mem_q[rptr_q[PW-1:0]] : 3'd0;
`else
  assign chan_o = 3'd0;
`endif

endmodule

// File: tb/tb_daq_adc_reader.sv
// Scoreboard bench for daq_adc_reader: frames are queued as expected words when a conversion is
// launched and compared as the FIFO head is accepted.
module tb_daq_adc_reader;

  localparam int unsigned NCH = 8;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        en_i = 1'b1;
  logic        busy_i = 1'b0;
  logic        ready_i = 1'b0;
  logic [15:0] adc_db_i;
  logic        adc_cs_n_o, adc_rd_n_o, valid_o, frame_done_o, overflow_o, timeout_o;
  logic [15:0] sample_o;
  logic [2:0]  chan_o;

  daq_adc_reader dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .en_i         (en_i),
    .busy_i       (busy_i),
    .adc_db_i     (adc_db_i),
    .adc_cs_n_o   (adc_cs_n_o),
    .adc_rd_n_o   (adc_rd_n_o),
    .sample_o     (sample_o),
    .chan_o       (chan_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .frame_done_o (frame_done_o),
    .overflow_o   (overflow_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  chan;
  } exp_t;

  exp_t        exp_q [$];
  int          checks = 0;
  int          failures = 0;
  int          cs_low_cnt = 0;
  int          rd_fall_cnt = 0;
  int          done_cnt = 0;
  logic        rd_prev = 1'b1;
  logic [3:0]  word_idx = '0;
  logic [15:0] frame_base = '0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_sample = '0;
  logic [2:0]  prev_chan = '0;

  // ADC model: word n of a frame reads as frame_base + n
  assign adc_db_i = frame_base + 16'(word_idx);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] exp_chan(input int c);
`ifdef ADC_CHAN_TAG_EN
    return 3'(c);
`else
    return 3'd0 & 3'(c);
`endif
  endfunction

  always @(negedge clk_i) begin
    rd_prev <= adc_rd_n_o;
    if (!adc_cs_n_o) cs_low_cnt <= cs_low_cnt + 1;
    if (!adc_rd_n_o && rd_prev) rd_fall_cnt <= rd_fall_cnt + 1;
    if (frame_done_o) done_cnt <= done_cnt + 1;
    if (adc_cs_n_o) word_idx <= '0;
    else if (adc_rd_n_o && !rd_prev) word_idx <= word_idx + 1'b1;
  end

  // Output side of the scoreboard, plus hold-while-stalled check
  always @(negedge clk_i) begin
    exp_t e;
    if (reset_i) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", 32'(valid_o), 32'd1);
        check_eq("stall_sample", 32'(sample_o), 32'(prev_sample));
        check_eq("stall_chan", 32'(chan_o), 32'(prev_chan));
      end
      if (valid_o && ready_i) begin
        check_eq("word_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check_eq("sample", 32'(sample_o), 32'(e.data));
          check_eq("chan", 32'(chan_o), 32'(e.chan));
        end
      end
      prev_stall  = valid_o && !ready_i;
      prev_sample = sample_o;
      prev_chan   = chan_o;
    end
  end

  task automatic push_frame(input logic [15:0] base);
    for (int c = 0; c < NCH; c++) exp_q.push_back(exp_t'{base + 16'(c), exp_chan(c)});
    frame_base = base;
  endtask

  task automatic busy_pulse(input int hi);
    @(posedge clk_i);
    #1 busy_i = 1'b1;
    repeat (hi) @(posedge clk_i);
    #1 busy_i = 1'b0;
  endtask

  task automatic wait_rd(input int target);
    int n = 0;
    while (rd_fall_cnt < target && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 500) check_eq("rd_wait_timeout", 32'(rd_fall_cnt), 32'(target));
  endtask

  task automatic drain();
    int n = 0;
    @(posedge clk_i);
    #1 ready_i = 1'b1;
    while (exp_q.size() != 0 && n < 400) begin
      @(posedge clk_i);
      n++;
    end
    repeat (2) @(posedge clk_i);
    check_eq("drained", 32'(exp_q.size()), 32'd0);
  endtask

  int   cs0, rd0, dn0;
  logic done6;

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_eq("rst_cs_n", 32'(adc_cs_n_o), 32'd1);
    check_eq("rst_rd_n", 32'(adc_rd_n_o), 32'd1);
    check_eq("rst_valid", 32'(valid_o), 32'd0);
    check_eq("rst_done", 32'(frame_done_o), 32'd0);
    check_eq("rst_ovf", 32'(overflow_o), 32'd0);
    check_eq("rst_to", 32'(timeout_o), 32'd0);
    check_eq("rst_sample", 32'(sample_o), 32'd0);
    check_eq("rst_chan", 32'(chan_o), 32'd0);
    reset_i = 1'b0;

    // Single frame, consumer always ready
    ready_i = 1'b1;
    cs0 = cs_low_cnt; rd0 = rd_fall_cnt; dn0 = done_cnt;
    push_frame(16'h1000);
    busy_pulse(20);
    repeat (60) @(posedge clk_i);
    check_eq("t1_cs_low_cycles", 32'(cs_low_cnt - cs0), 32'd41);
    check_eq("t1_rd_strobes", 32'(rd_fall_cnt - rd0), 32'd8);
    check_eq("t1_frame_done", 32'(done_cnt - dn0), 32'd1);
    check_eq("t1_all_words", 32'(exp_q.size()), 32'd0);

    // Backpressure: four frames fill the FIFO, the fifth is dropped whole
    ready_i = 1'b0;
    for (int f = 0; f < 4; f++) begin
      push_frame(16'h2000 + 16'(f * 16));
      busy_pulse(20);
      repeat (60) @(posedge clk_i);
    end
    check_eq("t2_full_valid", 32'(valid_o), 32'd1);
    check_eq("t2_ovf_before", 32'(overflow_o), 32'd0);
    rd0 = rd_fall_cnt; cs0 = cs_low_cnt;
    frame_base = 16'h2400;
    busy_pulse(20);
    repeat (60) @(posedge clk_i);
    check_eq("t2_ovf", 32'(overflow_o), 32'd1);
    check_eq("t2_drop_no_rd", 32'(rd_fall_cnt - rd0), 32'd0);
    check_eq("t2_drop_no_cs", 32'(cs_low_cnt - cs0), 32'd0);
    @(posedge clk_i);
    #1 ready_i = 1'b1;
    repeat (8) @(posedge clk_i);
    #1 ready_i = 1'b0;
    check_eq("t2_after_pop8", 32'(exp_q.size()), 32'd24);
    rd0 = rd_fall_cnt;
    push_frame(16'h2600);
    busy_pulse(20);
    repeat (60) @(posedge clk_i);
    check_eq("t2_sixth_rd", 32'(rd_fall_cnt - rd0), 32'd8);
    drain();
    check_eq("t2_ovf_sticky", 32'(overflow_o), 32'd1);

    // Busy timeout
    rd0 = rd_fall_cnt;
    busy_pulse(4100);
    repeat (20) @(posedge clk_i);
    check_eq("t3_timeout", 32'(timeout_o), 32'd1);
    check_eq("t3_no_rd", 32'(rd_fall_cnt - rd0), 32'd0);
    check_eq("t3_cs_idle", 32'(adc_cs_n_o), 32'd1);
    push_frame(16'h3000);
    busy_pulse(20);
    repeat (60) @(posedge clk_i);
    check_eq("t3_next_frame", 32'(rd_fall_cnt - rd0), 32'd8);
    check_eq("t3_words", 32'(exp_q.size()), 32'd0);
    check_eq("t3_to_sticky", 32'(timeout_o), 32'd1);

    // Enable gating
    en_i = 1'b0;
    rd0 = rd_fall_cnt;
    busy_pulse(20);
    repeat (60) @(posedge clk_i);
    check_eq("t4_disabled", 32'(rd_fall_cnt - rd0), 32'd0);
    en_i = 1'b1;
    rd0 = rd_fall_cnt;
    push_frame(16'h4000);
    busy_pulse(20);
    wait_rd(rd0 + 4);
    en_i = 1'b0;
    repeat (60) @(posedge clk_i);
    check_eq("t4_frame_completes", 32'(rd_fall_cnt - rd0), 32'd8);
    check_eq("t4_words", 32'(exp_q.size()), 32'd0);
    rd0 = rd_fall_cnt;
    busy_pulse(20);
    repeat (60) @(posedge clk_i);
    check_eq("t4_no_more", 32'(rd_fall_cnt - rd0), 32'd0);
    en_i = 1'b1;

    // Reset during RD_LOW of channel 4; captured words stay unread and are flushed
    ready_i = 1'b0;
    rd0 = rd_fall_cnt;
    frame_base = 16'h5500;
    busy_pulse(20);
    wait_rd(rd0 + 5);
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    check_eq("t5_cs_n", 32'(adc_cs_n_o), 32'd1);
    check_eq("t5_rd_n", 32'(adc_rd_n_o), 32'd1);
    check_eq("t5_valid", 32'(valid_o), 32'd0);
    check_eq("t5_ovf", 32'(overflow_o), 32'd0);
    check_eq("t5_to", 32'(timeout_o), 32'd0);
    @(posedge clk_i);
    #1 reset_i = 1'b0;
    ready_i = 1'b1;
    dn0 = done_cnt;
    push_frame(16'h5000);
    busy_pulse(20);
    repeat (60) @(posedge clk_i);
    check_eq("t5_clean_frame", 32'(exp_q.size()), 32'd0);
    check_eq("t5_done", 32'(done_cnt - dn0), 32'd1);

    // Random backpressure over 100 frames
    done6 = 1'b0;
    fork
      begin
        for (int f = 0; f < 100; f++) begin
          push_frame(16'($urandom));
          busy_pulse(int'($urandom_range(5, 30)));
          repeat (50) @(posedge clk_i);
        end
        done6 = 1'b1;
      end
      begin
        while (!done6) begin
          @(posedge clk_i);
          #1 ready_i = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
    check_eq("t6_no_ovf", 32'(overflow_o), 32'd0);
    check_eq("t6_no_to", 32'(timeout_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
